// File: rtl/sm4_seq_pkg.sv
// Shared types and constants for the SM4 job sequencer slice.
// Holds the sequencer state enum, engine command codes and bus widths.
package sm4_seq_pkg;

  localparam int DATA_W = 128;
  localparam int BUS_W  = 384;
  localparam int GNUM_W = 32;

  localparam logic [1:0] CMD_ENC = 2'b10;
  localparam logic [1:0] CMD_DEC = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    KEYUP,
    LOAD,
    SEND,
    COLLECT,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/sm4_seq_outreg.sv
// One-deep valid/ready output register for SM4 results and their group numbers.
// busy means a result is still waiting and will not be taken this cycle.
module sm4_seq_outreg
  import sm4_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [GNUM_W-1:0] load_gnum,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [GNUM_W-1:0] out_group_num
);

  assign busy = out_valid && !out_ready;

  // Data and group number only move on load, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_group_num <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_data      <= load_data;
      out_group_num <= load_gnum;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sm4_job_sequencer.sv
// Drives the SM4 group engine through a multi-group job, one group in flight.
// Optional per-group watchdog is enabled with `define SM4_SEQ_TIMEOUT_EN.
module sm4_job_sequencer
  import sm4_seq_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  input  logic [1:0]        job_mode,
  input  logic [DATA_W-1:0] job_key,
  input  logic [GNUM_W-1:0] job_first_group,
  input  logic [GNUM_W-1:0] job_count,
  output logic              busy,
  output logic              job_done,
  output logic              job_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [GNUM_W-1:0] out_group_num,
  output logic              eng_start,
  output logic [GNUM_W-1:0] eng_first_group,
  output logic [DATA_W-1:0] eng_key,
  output logic [1:0]        eng_cmd,
  output logic [BUS_W-1:0]  eng_din,
  output logic              eng_send_ok,
  output logic              eng_out_ok,
  input  logic [BUS_W-1:0]  eng_dout,
  input  logic              eng_round_ok,
  input  logic [GNUM_W-1:0] eng_end_group
);

  seq_state_e        state, state_nxt;
  logic [GNUM_W-1:0] count_q;
  logic [GNUM_W-1:0] done_count;
  logic [31:0]       gap_cnt;
  logic [DATA_W-1:0] din_q;
  logic              armed;
  logic              accept_job;
  logic              out_busy;
  logic              out_load;
  logic              timeout_hit;
  logic              unused_dout;

  assign accept_job  = job_start && (state == IDLE) && !busy;
  assign eng_din     = {{(BUS_W-DATA_W){1'b0}}, din_q};
  assign unused_dout = ^eng_dout[BUS_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_job && job_count != '0) state_nxt = GAP;
      GAP:     if (gap_cnt == 32'(GAP_CYCLES - 1)) state_nxt = KEYUP;
      KEYUP:   state_nxt = LOAD;
      LOAD:    if (in_valid) state_nxt = SEND;
      SEND: begin
        if (timeout_hit)                state_nxt = IDLE;
        else if (armed && eng_round_ok) state_nxt = COLLECT;
      end
      COLLECT: if (!out_busy) state_nxt = (done_count == count_q - 1'b1) ? DRAIN : LOAD;
      DRAIN:   if (!out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == LOAD);
    eng_send_ok = (state == SEND);
    eng_start   = (state == KEYUP) || (state == LOAD) || (state == SEND) || (state == COLLECT);
    out_load    = (state == COLLECT) && !out_busy;
    eng_out_ok  = out_load;
  end

  // Job parameters stay latched after the job so the engine sees stable values.
  // A high round_ok left over from the previous group is ignored until it has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      job_done        <= 1'b0;
      eng_cmd         <= 2'b00;
      eng_key         <= '0;
      eng_first_group <= '0;
      count_q         <= '0;
      done_count      <= '0;
      gap_cnt         <= '0;
      din_q           <= '0;
      armed           <= 1'b0;
    end else begin
      job_done <= 1'b0;
      if (accept_job) begin
        eng_cmd         <= job_mode;
        eng_key         <= job_key;
        eng_first_group <= job_first_group;
        count_q         <= job_count;
        done_count      <= '0;
        busy            <= 1'b1;
        if (job_count == '0) job_done <= 1'b1;
      end
      if (state == IDLE && busy) busy <= 1'b0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 32'd0;
      if (state == LOAD && in_valid) begin
        din_q <= in_data;
        armed <= 1'b0;
      end
      if (state == SEND && !eng_round_ok) armed <= 1'b1;
      if (out_load) done_count <= done_count + 1'b1;
      if (state == DRAIN && !out_valid) begin
        job_done <= 1'b1;
        busy     <= 1'b0;
      end
      if (timeout_hit) busy <= 1'b0;
    end
  end

`ifdef SM4_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        job_err_q;

  assign timeout_hit = (state == SEND) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign job_err     = job_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      job_err_q <= 1'b0;
    end else begin
      job_err_q <= timeout_hit;
      if (state == LOAD && in_valid) tmo_cnt <= '0;
      else if (state == SEND)        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign job_err     = 1'b0;
`endif

  sm4_seq_outreg u_outreg (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (timeout_hit),
    .load          (out_load),
    .load_data     (eng_dout[DATA_W-1:0]),
    .load_gnum     (eng_end_group),
    .out_ready     (out_ready),
    .busy          (out_busy),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_group_num (out_group_num)
  );

endmodule

// File: tb/tb_sm4_job_sequencer.sv
// Self-checking bench for sm4_job_sequencer with a reactive SM4 engine model.
// Results are checked against a job-level scoreboard built from the job parameters.
module tb_sm4_job_sequencer;
  import sm4_seq_pkg::*;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         job_start = 1'b0;
  logic [1:0]   job_mode = 2'b00;
  logic [127:0] job_key = '0;
  logic [31:0]  job_first_group = '0;
  logic [31:0]  job_count = '0;
  logic         busy, job_done, job_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [31:0]  out_group_num;
  logic         eng_start;
  logic [31:0]  eng_first_group;
  logic [127:0] eng_key;
  logic [1:0]   eng_cmd;
  logic [383:0] eng_din;
  logic         eng_send_ok, eng_out_ok;
  logic [383:0] eng_dout = '0;
  logic         eng_round_ok = 1'b0;
  logic [31:0]  eng_end_group = '0;

  always #5 clk = ~clk;

  sm4_job_sequencer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_mode(job_mode), .job_key(job_key),
    .job_first_group(job_first_group), .job_count(job_count), .busy(busy), .job_done(job_done),
    .job_err(job_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_group_num(out_group_num),
    .eng_start(eng_start), .eng_first_group(eng_first_group), .eng_key(eng_key), .eng_cmd(eng_cmd),
    .eng_din(eng_din), .eng_send_ok(eng_send_ok), .eng_out_ok(eng_out_ok), .eng_dout(eng_dout),
    .eng_round_ok(eng_round_ok), .eng_end_group(eng_end_group)
  );

  typedef struct {logic [127:0] d; logic [31:0] g;} exp_t;
  exp_t         exp_q[$];
  logic [127:0] got_d[$];
  logic [31:0]  got_g[$];
  int           n_cmp = 0, n_bad = 0;
  int           out_ok_cnt = 0;
  bit           eng_start_seen = 0;
  logic [1:0]   cur_mode = 2'b00;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for SM4: the standard test vector is exact, everything else a keyed mix.
  function automatic logic [127:0] xform(input logic [127:0] d, input logic [127:0] k,
                                         input logic [1:0] c, input logic [31:0] g);
    if (c == CMD_ENC && d == 128'h0123456789abcdeffedcba9876543210 &&
        k == 128'h0123456789abcdeffedcba9876543210)
      return 128'h681edf34d206965e86b3e94f536e4246;
    return d ^ {k[63:0], k[127:64]} ^ {96'h0, g} ^ ((c == CMD_DEC) ? {128{1'b1}} : 128'h0);
  endfunction

  // Engine model: result after eng_lat cycles (0 = never); round_ok held until next send_ok.
  int           eng_lat = 32;
  bit           eng_stale = 0;
  bit           computing = 0;
  int           cnt = 0, stale_left = 0, gcount = 0;
  logic [127:0] cap_din = '0;

  always @(negedge clk) begin
    if (!rst_n || !eng_start) begin
      eng_round_ok = 1'b0;
      computing = 0;
      gcount = 0;
      stale_left = 0;
    end else begin
      if (eng_out_ok) gcount++;
      if (eng_send_ok && !computing) begin
        computing = 1;
        cnt = eng_lat;
        cap_din = eng_din[127:0];
        if (eng_stale && eng_round_ok) stale_left = 3;
        else eng_round_ok = 1'b0;
      end else if (computing) begin
        if (stale_left > 0) begin
          stale_left--;
          if (stale_left == 0) eng_round_ok = 1'b0;
        end
        if (eng_lat > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng_end_group = eng_first_group + 32'(gcount);
            eng_dout = {256'h0, xform(cap_din, eng_key, eng_cmd, eng_end_group)};
            eng_round_ok = 1'b1;
            computing = 0;
          end
        end
      end
    end
  end

  // Out-ready driver: optional 20-cycle stall starting when the first result appears.
  int bp_cnt = 0;
  bit bp_arm = 0;
  always @(posedge clk) begin
    #1;
    if (bp_arm && out_valid) begin
      bp_arm = 0;
      bp_cnt = 20;
    end
    if (bp_cnt > 0) begin
      out_ready = 1'b0;
      bp_cnt--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Per-cycle checker against the scoreboard and the handshake rules.
  bit           prev_stall = 0;
  logic [127:0] prev_d = '0;
  logic [31:0]  prev_g = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (eng_start) begin
        eng_start_seen = 1;
        checkOutput("eng_cmd", 128'(eng_cmd), 128'(cur_mode));
      end
      if (eng_out_ok) begin
        out_ok_cnt++;
        checkOutput("out_ok_when_free", 128'(!out_valid || out_ready), 128'd1);
      end
      if (prev_stall) begin
        checkOutput("hold_valid", 128'(out_valid), 128'd1);
        checkOutput("hold_data", out_data, prev_d);
        checkOutput("hold_gnum", 128'(out_group_num), 128'(prev_g));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 128'd1, 128'd0);
        end else begin
          checkOutput("out_data", out_data, exp_q[0].d);
          checkOutput("out_group_num", 128'(out_group_num), 128'(exp_q[0].g));
          void'(exp_q.pop_front());
        end
        got_d.push_back(out_data);
        got_g.push_back(out_group_num);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_g = out_group_num;
    end
  end

  task automatic pulseStart(input logic [1:0] mode, input logic [127:0] key,
                            input logic [31:0] first, input logic [31:0] count);
    job_mode = mode;
    job_key = key;
    job_first_group = first;
    job_count = count;
    job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic feedGroup(input logic [127:0] d, input int budget);
    bit ok = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("in_accept", 128'(ok), 128'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [127:0] key, input logic [127:0] data0,
                               input logic [31:0] first, input logic [31:0] count, input int lat,
                               input bit stale, input bit bp, input bit dup_start);
    bit ok = 0;
    eng_lat = lat;
    eng_stale = stale;
    cur_mode = mode;
    out_ok_cnt = 0;
    got_d.delete();
    got_g.delete();
    for (int i = 0; i < int'(count); i++)
      exp_q.push_back('{xform(data0 + 128'(i), key, mode, first + 32'(i)), first + 32'(i)});
    @(posedge clk); #1;
    bp_arm = bp;
    pulseStart(mode, key, first, count);
    for (int i = 0; i < int'(count); i++) begin
      feedGroup(data0 + 128'(i), 300);
      if (dup_start && i == 0) pulseStart(~mode, ~key, 32'h55, 32'd5);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (job_done) begin ok = 1; break; end
    end
    checkOutput("job_done", 128'(ok), 128'd1);
    checkOutput("busy_after_done", 128'(busy), 128'd0);
    checkOutput("result_count", 128'(got_d.size()), 128'(count));
    checkOutput("out_ok_count", 128'(out_ok_cnt), 128'(count));
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] idleVec();
    return 128'({busy, job_done, job_err, in_ready, out_valid, eng_start, eng_send_ok, eng_out_ok,
                 |out_data, |out_group_num, |eng_key, |eng_cmd, |eng_first_group, |eng_din});
  endfunction

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    k1 = 128'h0123456789abcdeffedcba9876543210;
    k2 = 128'hfedcba98765432100123456789abcdef;
    #3;
    checkOutput("reset_outputs", idleVec(), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single-group encrypt");
    applyStimulus(CMD_ENC, k1, k1, 32'h0, 32'd1, 32, 0, 0, 0);
    if (got_d.size() == 1) begin
      checkOutput("t1_literal_data", got_d[0], 128'h681edf34d206965e86b3e94f536e4246);
      checkOutput("t1_literal_gnum", 128'(got_g[0]), 128'd0);
    end

    $display("[TB] four-group decrypt with group number wrap");
    applyStimulus(CMD_DEC, k2, 128'h00112233445566778899aabbccddeeff, 32'hFFFFFFFE, 32'd4, 10, 0, 0, 0);
    if (got_g.size() == 4) begin
      checkOutput("t2_gnum0", 128'(got_g[0]), 128'hFFFFFFFE);
      checkOutput("t2_gnum1", 128'(got_g[1]), 128'hFFFFFFFF);
      checkOutput("t2_gnum2", 128'(got_g[2]), 128'h0);
      checkOutput("t2_gnum3", 128'(got_g[3]), 128'h1);
    end

    $display("[TB] stale round_ok");
    applyStimulus(CMD_ENC, k2, 128'hA5A5, 32'h100, 32'd2, 8, 1, 0, 0);
    if (got_g.size() == 2) checkOutput("t3_gnum1", 128'(got_g[1]), 128'h101);

    $display("[TB] output backpressure");
    applyStimulus(CMD_ENC, k1, 128'h77, 32'h20, 32'd3, 4, 0, 1, 0);
    if (got_g.size() == 3) begin
      checkOutput("t4_gnum0", 128'(got_g[0]), 128'h20);
      checkOutput("t4_gnum2", 128'(got_g[2]), 128'h22);
    end

    $display("[TB] zero-count job");
    eng_start_seen = 0;
    @(posedge clk); #1;
    pulseStart(CMD_ENC, k1, 32'h0, 32'd0);
    checkOutput("cnt0_job_done", 128'(job_done), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("cnt0_busy", 128'(busy), 128'd0);
    checkOutput("cnt0_eng_start", 128'(eng_start_seen), 128'd0);

    $display("[TB] job_start while busy");
    applyStimulus(CMD_DEC, k1, 128'h1234, 32'h40, 32'd3, 6, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dup_no_second_job", 128'(busy), 128'd0);

`ifdef SM4_SEQ_TIMEOUT_EN
    begin
      int  sc = 0;
      bit  err_seen = 0;
      bit  done_seen = 0;
      $display("[TB] engine timeout");
      eng_lat = 0;
      cur_mode = CMD_ENC;
      @(posedge clk); #1;
      pulseStart(CMD_ENC, k1, 32'h0, 32'd1);
      feedGroup(128'h99, 100);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (job_done) done_seen = 1;
        if (eng_send_ok) sc++;
        if (job_err) begin
          err_seen = 1;
          checkOutput("tmo_eng_start", 128'(eng_start), 128'd0);
          checkOutput("tmo_busy", 128'(busy), 128'd0);
          break;
        end
      end
      checkOutput("tmo_job_err", 128'(err_seen), 128'd1);
      checkOutput("tmo_send_cycles", 128'(sc), 128'(TMO));
      checkOutput("tmo_no_done", 128'(done_seen), 128'd0);
    end
`endif

    begin
      bit sent = 0;
      $display("[TB] reset during SEND");
      eng_lat = 0;
      cur_mode = CMD_DEC;
      @(posedge clk); #1;
      pulseStart(CMD_DEC, k2, 32'h7, 32'd2);
      feedGroup(128'h4242, 100);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (eng_send_ok) begin sent = 1; break; end
      end
      checkOutput("rst_reached_send", 128'(sent), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_outputs", idleVec(), 128'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end

    $display("[TB] recovery job after reset");
    applyStimulus(CMD_ENC, k2, 128'hBEEF, 32'h9, 32'd2, 5, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
